display_scan_ctrl: RTL and testbench

- Time-multiplexes three 7-segment digit patterns onto the single shared segment bus d7sp, one digit at a time, with one-hot digit-enable drive on transistor.
- Inserts dead-time between digits so no ghosting occurs.
- Accepts new display contents through a valid/ready handshake and applies them only at frame boundaries, so a frame is never torn.
- Sits between the BCD/segment-table path and the board pins.

---
 rtl/display_scan_ctrl.sv | 121 ++++++++++++
 tb/tb_display_scan_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Three-digit 7-segment scan controller: dead-time between digits, frame-aligned
// display updates, leading-zero blanking. Define DISPLAY_SCAN_DIM_EN for PWM dimming.
module display_scan_ctrl #(
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg1_in,
  input  logic [6:0] seg2_in,
  input  logic [6:0] seg3_in,
  input  logic       upd_valid,
  output logic       upd_ready,
  input  logic       lzb_en,
`ifdef DISPLAY_SCAN_DIM_EN
  input  logic [3:0] dim,
`endif
  output logic [2:0] transistor,
  output logic [6:0] d7sp,
  output logic       frame_tick,
  output logic [1:0] cur_digit
);

  localparam int unsigned CW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [6:0]  ZERO = 7'b0000001;
  localparam logic [6:0]  OFF  = 7'h7F;

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   off_q, off_d;
  logic [1:0]      slot_q, slot_d;
  logic [2:0][6:0] disp_q, disp_d;
  logic [2:0][6:0] pend_q, pend_d;
  logic            pend_full_q, pend_full_d;
  logic [2:0]      transistor_q, transistor_d;
  logic [6:0]      d7sp_q, d7sp_d;
  logic            frame_tick_q, frame_tick_d;
  logic            boundary, in_blank, suppress, lit;

  always_comb begin
    off_d        = off_q + 1'b1;
    slot_d       = slot_q;
    disp_d       = disp_q;
    pend_d       = pend_q;
    pend_full_d  = pend_full_q;
    transistor_d = 3'b111;
    d7sp_d       = OFF;

    if (off_q == CW'(SCAN_DIV - 1)) begin
      off_d  = '0;
      slot_d = (slot_q == 2'd2) ? 2'd0 : slot_q + 2'd1;
    end
    boundary     = (off_d == '0) && (slot_d == 2'd0);
    frame_tick_d = boundary;

    // A full buffer blocks new captures, so load and capture never collide.
    if (boundary && pend_full_q) begin
      disp_d      = pend_q;
      pend_full_d = 1'b0;
    end else if (upd_valid && !pend_full_q) begin
      pend_d      = {seg3_in, seg2_in, seg1_in};
      pend_full_d = 1'b1;
    end

    in_blank = 32'(off_d) < BLANK_CYC;
    suppress = lzb_en && (((slot_d == 2'd2) && (disp_d[2] == ZERO)) ||
                          ((slot_d == 2'd1) && (disp_d[2] == ZERO) && (disp_d[1] == ZERO)));
`ifdef DISPLAY_SCAN_DIM_EN
    lit = ((32'(off_d) - BLANK_CYC) * 32'd16) < ((SCAN_DIV - BLANK_CYC) * (32'(dim) + 32'd1));
`else
    lit = 1'b1;
`endif

    state_d = (in_blank || suppress || !lit) ? ST_BLANK : ST_SHOW;
    if (state_d == ST_SHOW) begin
      case (slot_d)
        2'd0:    begin transistor_d = 3'b110; d7sp_d = disp_d[0]; end
        2'd1:    begin transistor_d = 3'b101; d7sp_d = disp_d[1]; end
        2'd2:    begin transistor_d = 3'b011; d7sp_d = disp_d[2]; end
        default: begin transistor_d = 3'b111; d7sp_d = OFF; end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_BLANK;
      off_q        <= '0;
      slot_q       <= '0;
      disp_q       <= {ZERO, ZERO, ZERO};
      pend_q       <= {ZERO, ZERO, ZERO};
      pend_full_q  <= 1'b0;
      transistor_q <= 3'b111;
      d7sp_q       <= OFF;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      off_q        <= off_d;
      slot_q       <= slot_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_full_q  <= pend_full_d;
      transistor_q <= transistor_d;
      d7sp_q       <= d7sp_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // Digit drivers are off exactly when the slot FSM sits in BLANK.
  always_ff @(posedge clk) begin
    if (rst) assert ((state_q == ST_BLANK) == (transistor_q == 3'b111));
  end

  assign transistor = transistor_q;
  assign d7sp       = d7sp_q;
  assign frame_tick = frame_tick_q;
  assign cur_digit  = slot_q;
  assign upd_ready  = !pend_full_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl with SCAN_DIV=8, BLANK_CYC=2: a position-based
// reference model pushes expected outputs per edge, popped and compared 1 time unit later.
module tb_display_scan_ctrl;
  localparam int unsigned SD    = 8;
  localparam int unsigned BC    = 2;
  localparam int unsigned FRAME = 3 * SD;
  localparam logic [6:0]  ZERO  = 7'b0000001;
  localparam logic [6:0]  OFF   = 7'h7F;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg1_in = ZERO, seg2_in = ZERO, seg3_in = ZERO;
  logic       upd_valid = 1'b0;
  logic       upd_ready;
  logic       lzb_en = 1'b0;
  logic [2:0] transistor;
  logic [6:0] d7sp;
  logic       frame_tick;
  logic [1:0] cur_digit;
`ifdef DISPLAY_SCAN_DIM_EN
  logic [3:0] dim = 4'd15;
`endif

  display_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst(rst),
    .seg1_in(seg1_in), .seg2_in(seg2_in), .seg3_in(seg3_in),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .lzb_en(lzb_en),
`ifdef DISPLAY_SCAN_DIM_EN
    .dim(dim),
`endif
    .transistor(transistor), .d7sp(d7sp), .frame_tick(frame_tick), .cur_digit(cur_digit)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] tr;
    logic [6:0] seg;
    logic       tick;
    logic [1:0] dig;
    logic       rdy;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          fails  = 0;
  int unsigned n;
  logic [6:0]  m_disp[3];
  logic [6:0]  m_pend[3];
  logic        m_full;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h edge=%0d", tag, obs, exp_v, n);
    end
  endtask

  task automatic model_reset();
    n      = 0;
    m_full = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_disp[i] = ZERO;
      m_pend[i] = ZERO;
    end
  endtask

  task automatic check_reset_values();
    chk("rst_transistor", 16'(transistor), 16'(3'b111));
    chk("rst_d7sp",       16'(d7sp),       16'(OFF));
    chk("rst_frame_tick", 16'(frame_tick), 16'(1'b0));
    chk("rst_cur_digit",  16'(cur_digit),  16'(2'd0));
    chk("rst_upd_ready",  16'(upd_ready),  16'(1'b1));
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    check_reset_values();
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic step();
    exp_t        e, got;
    int unsigned p, s, o;
    logic        show;
    logic [2:0]  tr;
    @(posedge clk);
    n++;
    p = n % FRAME;
    s = p / SD;
    o = p % SD;
    if (p == 0 && m_full) begin
      m_disp = m_pend;
      m_full = 1'b0;
    end else if (upd_valid && !m_full) begin
      m_pend[0] = seg1_in;
      m_pend[1] = seg2_in;
      m_pend[2] = seg3_in;
      m_full    = 1'b1;
    end
    show = (o >= BC) &&
           !(lzb_en && ((s == 2 && m_disp[2] == ZERO) ||
                        (s == 1 && m_disp[2] == ZERO && m_disp[1] == ZERO)));
    tr = 3'b111;
    if (show) tr[s] = 1'b0;
    e.tr   = tr;
    e.seg  = show ? m_disp[s] : OFF;
    e.tick = (p == 0);
    e.dig  = 2'(s);
    e.rdy  = !m_full;
    sb.push_back(e);
    #1;
    got = sb.pop_front();
    chk("transistor", 16'(transistor), 16'(got.tr));
    chk("d7sp",       16'(d7sp),       16'(got.seg));
    chk("frame_tick", 16'(frame_tick), 16'(got.tick));
    chk("cur_digit",  16'(cur_digit),  16'(got.dig));
    chk("upd_ready",  16'(upd_ready),  16'(got.rdy));
  endtask

  task automatic steps(input int unsigned k);
    for (int unsigned i = 0; i < k; i++) step();
  endtask

  task automatic drive_upd(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1);
    seg3_in   = s3;
    seg2_in   = s2;
    seg1_in   = s1;
    upd_valid = 1'b1;
  endtask

  initial begin
    model_reset();
    #1;
    do_reset();

    // Free-run: ZERO on every slot, frame ticks after edges 24 and 48.
    steps(48);

    // Update accepted at edge 3, second request held from edge 4 until edge 25.
    do_reset();
    steps(2);
    drive_upd(ZERO, ZERO, 7'b1001111);
    step();
    drive_upd(ZERO, ZERO, 7'b0000110);
    steps(5);
    seg2_in = 7'b0010010;
    steps(17);
    upd_valid = 1'b0;
    seg1_in   = 7'h00;
    seg2_in   = 7'h00;
    seg3_in   = 7'h00;
    steps(35);

    // Leading-zero blanking: only units, then units and tens.
    do_reset();
    lzb_en = 1'b1;
    drive_upd(ZERO, ZERO, 7'b0100100);
    step();
    upd_valid = 1'b0;
    steps(47);
    drive_upd(ZERO, 7'b1001111, 7'b0100100);
    step();
    upd_valid = 1'b0;
    steps(47);
    lzb_en = 1'b0;

    // Reset during slot 1 SHOW with an update pending.
    do_reset();
    steps(2);
    drive_upd(7'b0001111, 7'b0010010, 7'b0011000);
    step();
    upd_valid = 1'b0;
    steps(9);
    do_reset();
    steps(30);

    if (sb.size() != 0) begin
      checks++;
      fails++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
